instr_sequencer: RTL and testbench

- Generates the 6-bit `state` code consumed by control_unit, which registers `state` into `control_out`/`mem_write` on the next clock edge.
- Runs the fetch/decode/execute loop: start handshake, fetch cycles, a decode slot, then per-opcode execute sequences, until an ENDOP instruction or reset.
- Sits between the IR (opcode source) and control_unit, driving control_unit's `state` input directly.

---
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer producing the state code consumed by control_unit.
// Every output is registered, so `state` reflects the FSM state entered on the last edge.
module instr_sequencer #(
  parameter int unsigned OPW  = 8,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  output logic [5:0]      state,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [4:0] {
    StIdle,
    StFetch1,
    StFetch2,
    StFetch3,
    StDecode,
    StClac,
    StLdac1,
    StLdac2,
    StLdac3,
    StStac1,
    StStac2,
    StStac3,
    StMvacr,
    StMvrac,
    StAdd,
    StMul
  } fsm_e;

  fsm_e fsm_q, fsm_d;
  logic retire;
  logic bad_op;

  // DECODE shares code 0 with IDLE so the IR gets a settling slot with a null control word.
  function automatic logic [5:0] code_of(input fsm_e s);
    case (s)
      StFetch1: code_of = 6'd1;
      StFetch2: code_of = 6'd2;
      StFetch3: code_of = 6'd3;
      StClac:   code_of = 6'd4;
      StLdac1:  code_of = 6'd5;
      StLdac2:  code_of = 6'd6;
      StLdac3:  code_of = 6'd7;
      StStac1:  code_of = 6'd8;
      StStac2:  code_of = 6'd9;
      StStac3:  code_of = 6'd10;
      StMvacr:  code_of = 6'd11;
      StMvrac:  code_of = 6'd12;
      StAdd:    code_of = 6'd13;
      StMul:    code_of = 6'd14;
      default:  code_of = 6'd0;
    endcase
  endfunction

  always_comb begin
    fsm_d  = fsm_q;
    retire = 1'b0;
    bad_op = 1'b0;
    unique case (fsm_q)
      StIdle:   if (start) fsm_d = StFetch1;
      StFetch1: fsm_d = StFetch2;
      StFetch2: fsm_d = StFetch3;
      StFetch3: fsm_d = StDecode;
      StDecode: begin
        case (opcode)
          OPW'(1): fsm_d = StClac;
          OPW'(2): fsm_d = StLdac1;
          OPW'(3): fsm_d = StStac1;
          OPW'(4): fsm_d = StMvacr;
          OPW'(5): fsm_d = StMvrac;
          OPW'(6): fsm_d = StAdd;
          OPW'(7): fsm_d = StMul;
          OPW'(8): fsm_d = StIdle;
          OPW'(0): begin
            fsm_d  = StFetch1;
            retire = 1'b1;
          end
          default: begin
            fsm_d  = StFetch1;
            retire = 1'b1;
            bad_op = 1'b1;
          end
        endcase
      end
      StLdac1: fsm_d = StLdac2;
      StLdac2: fsm_d = StLdac3;
      StStac1: fsm_d = StStac2;
      StStac2: fsm_d = StStac3;
      StLdac3, StStac3, StClac, StMvacr, StMvrac, StAdd, StMul: begin
        fsm_d  = StFetch1;
        retire = 1'b1;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= StIdle;
      state       <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      fsm_q <= fsm_d;
      state <= code_of(fsm_d);
      busy  <= (fsm_d != StIdle);
      done  <= (fsm_q == StDecode) && (fsm_d == StIdle);
      if (fsm_q == StIdle && start) begin
        instr_count <= '0;
        illegal     <= 1'b0;
      end else begin
        if (retire) instr_count <= instr_count + CNTW'(1);
        if (bad_op) illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer: a queue-of-codes program model predicts every cycle.
// A second instance with a 4-bit counter exercises counter wrap-around alongside the default one.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  opcode;
  logic [5:0]  state, state4;
  logic        busy, done, illegal, busy4, done4, illegal4;
  logic [15:0] instr_count;
  logic [3:0]  count4;

  always #5 clock = ~clock;

  instr_sequencer #(.OPW(8), .CNTW(16)) u_dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .state(state),
    .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
  );

  instr_sequencer #(.OPW(8), .CNTW(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .state(state4),
    .busy(busy4), .done(done4), .illegal(illegal4), .instr_count(count4)
  );

  logic [37:0] obs;
  assign obs = {state, busy, done, illegal, instr_count, state4, busy4, done4, illegal4, count4};

  int total = 0;
  int bad   = 0;

  // Reference model: the upcoming state codes of the current instruction sit in a queue.
  logic [5:0]  m_state = 6'd0;
  logic        m_run = 1'b0, m_dec = 1'b0, m_done = 1'b0, m_ill = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [5:0]  seq[$];
  logic [7:0]  prog[$];

  function automatic logic [37:0] expv();
    return {m_state, m_run, m_done, m_ill, m_cnt[15:0], m_state, m_run, m_done, m_ill, m_cnt[3:0]};
  endfunction

  task automatic load(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input int n);
    seq.delete();
    if (n > 0) seq.push_back(a);
    if (n > 1) seq.push_back(b);
    if (n > 2) seq.push_back(c);
  endtask

  task automatic begin_fetch();
    m_state = 6'd1;
    load(6'd2, 6'd3, 6'd0, 3);
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_state = 6'd0; m_run = 1'b0; m_dec = 1'b0; m_ill = 1'b0; m_cnt = 32'd0;
      seq.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_cnt = 32'd0; m_ill = 1'b0;
        begin_fetch();
      end else begin
        m_state = 6'd0;
      end
    end else if (m_dec) begin
      m_dec = 1'b0;
      case (opcode)
        8'd1: load(6'd4, 6'd0, 6'd0, 1);
        8'd2: load(6'd5, 6'd6, 6'd7, 3);
        8'd3: load(6'd8, 6'd9, 6'd10, 3);
        8'd4: load(6'd11, 6'd0, 6'd0, 1);
        8'd5: load(6'd12, 6'd0, 6'd0, 1);
        8'd6: load(6'd13, 6'd0, 6'd0, 1);
        8'd7: load(6'd14, 6'd0, 6'd0, 1);
        8'd8: begin m_run = 1'b0; m_done = 1'b1; end
        default: begin
          if (opcode != 8'd0) m_ill = 1'b1;
          seq.delete();
        end
      endcase
      if (!m_run) m_state = 6'd0;
      else if (seq.size() == 0) begin m_cnt++; begin_fetch(); end
      else m_state = seq.pop_front();
    end else if (seq.size() != 0) begin
      m_state = seq.pop_front();
      if (m_state == 6'd0) m_dec = 1'b1;
    end else begin
      m_cnt++;
      begin_fetch();
    end
  endtask

  // Drive inputs on the falling edge; opcode is only meaningful in the decode slot.
  task automatic cycle(input logic rst, input logic st);
    @(negedge clock);
    reset = rst;
    start = st;
    if (m_dec) opcode = (prog.size() != 0) ? prog.pop_front() : 8'd8;
    else       opcode = 8'($urandom);
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 1);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL reset cyc%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_clac();
    int want[$];
    int got[$];
    want = '{1, 2, 3, 0, 4, 1};
    prog.delete();
    prog = '{8'd1, 8'd1, 8'd8};
    cycle(1'b0, 1'b1);
    got.push_back(int'(state));
    for (int i = 0; i < 60 && m_run; i++) begin
      cycle(1'b0, 1'b0);
      got.push_back(int'(state));
      if (i == 4) begin
        total++;
        if (instr_count !== 16'd1) begin
          bad++;
          $display("FAIL clac_count: got %0d want 1", instr_count);
        end
      end
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL clac cyc%0d: got %h want %h", i, obs, expv());
      end
    end
    for (int i = 0; i < want.size(); i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL clac_seq[%0d]: got %0d want %0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_program();
    int want[$];
    int got[$];
    int dones = 0;
    want = '{1, 2, 3, 0, 5, 6, 7, 1, 2, 3, 0, 8, 9, 10, 1, 2, 3, 0, 0};
    prog.delete();
    prog = '{8'd2, 8'd3, 8'd8};
    cycle(1'b0, 1'b1);
    got.push_back(int'(state));
    for (int i = 0; i < 60 && m_run; i++) begin
      cycle(1'b0, 1'b0);
      got.push_back(int'(state));
      if (done === 1'b1) dones++;
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL program cyc%0d: got %h want %h", i, obs, expv());
      end
    end
    total++;
    if (got.size() != want.size()) begin
      bad++;
      $display("FAIL program_len: got %0d want %0d", got.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL program_seq[%0d]: got %0d want %0d", i, got[i], want[i]);
      end
    end
    total++;
    if (dones !== 1 || instr_count !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL program_end: got done=%0d cnt=%0d busy=%b want 1 2 0", dones, instr_count, busy);
    end
    cycle(1'b0, 1'b0);
    total++;
    if (done !== 1'b0 || instr_count !== 16'd2) begin
      bad++;
      $display("FAIL program_hold: got done=%b cnt=%0d want 0 2", done, instr_count);
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog = '{8'hFF, 8'd1, 8'd8};
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 60 && m_run; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, obs, expv());
      end
    end
    total++;
    if (illegal !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky: got %b want 1", illegal);
    end
    prog.delete();
    prog = '{8'd0, 8'd8};
    cycle(1'b0, 1'b1);
    total++;
    if (illegal !== 1'b0 || instr_count !== 16'd0 || state !== 6'd1) begin
      bad++;
      $display("FAIL illegal_clear: got ill=%b cnt=%0d st=%0d want 0 0 1", illegal, instr_count, state);
    end
    for (int i = 0; i < 60 && m_run; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    prog.delete();
    prog = '{8'd0, 8'd2, 8'd8};
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 40 && m_state != 6'd6; i++) cycle(1'b0, 1'b0);
    total++;
    if (state !== 6'd6) begin
      bad++;
      $display("FAIL reset_mid_reach: got %0d want 6", state);
    end
    cycle(1'b1, 1'b1);
    total++;
    if (state !== 6'd0 || busy !== 1'b0 || instr_count !== 16'd0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got st=%0d busy=%b cnt=%0d ill=%b want 0 0 0 0",
               state, busy, instr_count, illegal);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (obs !== expv() || state === 6'd7) begin
        bad++;
        $display("FAIL reset_mid_after cyc%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_start_ignored();
    prog.delete();
    prog = '{8'd7, 8'd8};
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 40 && m_run; i++) begin
      cycle(1'b0, m_state == 6'd2 || m_state == 6'd14);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL start_ignored cyc%0d: got %h want %h", i, obs, expv());
      end
    end
    total++;
    if (instr_count !== 16'd1) begin
      bad++;
      $display("FAIL start_ignored_count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_wrap();
    int dones = 0;
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'd0);
    prog.push_back(8'd8);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 200 && m_run; i++) begin
      cycle(1'b0, 1'b0);
      if (done4 === 1'b1) dones++;
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL wrap cyc%0d: got %h want %h", i, obs, expv());
      end
    end
    total++;
    if (count4 !== 4'd0 || instr_count !== 16'd16 || dones !== 1) begin
      bad++;
      $display("FAIL wrap_end: got c4=%0d c16=%0d done=%0d want 0 16 1", count4, instr_count, dones);
    end
  endtask

  task automatic test_random();
    prog.delete();
    for (int i = 0; i < 1500; i++) begin
      if (prog.size() == 0) prog.push_back(8'($urandom_range(0, 11)));
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random cyc%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 8'd0;
    test_reset();
    test_clac();
    test_program();
    test_illegal();
    test_reset_mid();
    test_start_ignored();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
